// File: rtl/clock_tod_param_if.sv
// Bus bundle for the time-of-day counter: control, load fields and display outputs.
// Alarm signals exist only when ALARM_EN is defined.
interface clock_tod_param_if #(
   parameter int MS_W  = 10,
   parameter int SEC_W = 6,
   parameter int MIN_W = 6,
   parameter int HR_W  = 5
);
   logic                              tick_en;
   logic                              run;
   logic                              load;
   logic [HR_W-1:0]                   load_hr;
   logic [MIN_W-1:0]                  load_min;
   logic [SEC_W-1:0]                  load_sec;
   logic [MS_W-1:0]                   load_ms;
   logic                              mode_12h;
   logic [HR_W+MIN_W+SEC_W+MS_W-1:0]  disp_time;
   logic                              pm;
   logic                              sec_pulse;
   logic                              day_wrap;
   logic                              set_err;
`ifdef ALARM_EN
   logic                              alarm_wr;
   logic [HR_W-1:0]                   alarm_hr;
   logic [MIN_W-1:0]                  alarm_min;
   logic                              alarm_arm;
   logic                              alarm_hit;

   modport master (
      output tick_en, run, load, load_hr, load_min, load_sec, load_ms, mode_12h,
      output alarm_wr, alarm_hr, alarm_min, alarm_arm,
      input  disp_time, pm, sec_pulse, day_wrap, set_err, alarm_hit
   );
   modport slave (
      input  tick_en, run, load, load_hr, load_min, load_sec, load_ms, mode_12h,
      input  alarm_wr, alarm_hr, alarm_min, alarm_arm,
      output disp_time, pm, sec_pulse, day_wrap, set_err, alarm_hit
   );
`else
   modport master (
      output tick_en, run, load, load_hr, load_min, load_sec, load_ms, mode_12h,
      input  disp_time, pm, sec_pulse, day_wrap, set_err
   );
   modport slave (
      input  tick_en, run, load, load_hr, load_min, load_sec, load_ms, mode_12h,
      output disp_time, pm, sec_pulse, day_wrap, set_err
   );
`endif
endinterface

// File: rtl/clock_tod_param.sv
// Parametrised hr:min:sec:ms time-of-day counter with validated load and 12/24h display.
// Optional alarm compare is compiled in when ALARM_EN is defined.
module clock_tod_param #(
   parameter int MS_MOD  = 1000,
   parameter int SEC_MOD = 60,
   parameter int MIN_MOD = 60,
   parameter int HR_MOD  = 24,
   parameter int MS_W    = 10,
   parameter int SEC_W   = 6,
   parameter int MIN_W   = 6,
   parameter int HR_W    = 5
) (
   input  logic               kh_clk,
   input  logic               reset,
   clock_tod_param_if.slave   bus
);
   // One extra bit on the limits so a MOD of exactly 2^W still compares correctly.
   localparam logic [MS_W:0]    MS_LIM  = (MS_W+1)'(MS_MOD);
   localparam logic [SEC_W:0]   SEC_LIM = (SEC_W+1)'(SEC_MOD);
   localparam logic [MIN_W:0]   MIN_LIM = (MIN_W+1)'(MIN_MOD);
   localparam logic [HR_W:0]    HR_LIM  = (HR_W+1)'(HR_MOD);
   localparam logic [MS_W-1:0]  MS_MAX  = MS_W'(MS_MOD-1);
   localparam logic [SEC_W-1:0] SEC_MAX = SEC_W'(SEC_MOD-1);
   localparam logic [MIN_W-1:0] MIN_MAX = MIN_W'(MIN_MOD-1);
   localparam logic [HR_W-1:0]  HR_MAX  = HR_W'(HR_MOD-1);

   logic [MS_W-1:0]  ms_q,  ms_d;
   logic [SEC_W-1:0] sec_q, sec_d;
   logic [MIN_W-1:0] min_q, min_d;
   logic [HR_W-1:0]  hr_q,  hr_d;
   logic sec_pulse_q, sec_pulse_d, day_wrap_q, day_wrap_d, set_err_q, set_err_d;
   logic load_ok, advance, ms_wrap, sec_wrap, min_wrap, hr_wrap;
`ifdef ALARM_EN
   logic [HR_W-1:0]  alarm_hr_q,  alarm_hr_d;
   logic [MIN_W-1:0] alarm_min_q, alarm_min_d;
   logic             alarm_hit_q, alarm_hit_d;
   logic             alarm_ok;
`endif

   always_comb begin
      ms_d        = ms_q;
      sec_d       = sec_q;
      min_d       = min_q;
      hr_d        = hr_q;
      sec_pulse_d = 1'b0;
      day_wrap_d  = 1'b0;
      set_err_d   = 1'b0;
      load_ok     = bus.load &&
                    ({1'b0, bus.load_hr}  < HR_LIM)  && ({1'b0, bus.load_min} < MIN_LIM) &&
                    ({1'b0, bus.load_sec} < SEC_LIM) && ({1'b0, bus.load_ms}  < MS_LIM);
      advance     = bus.run && bus.tick_en && !bus.load;
      // Each wrap flag implies all lower fields wrap as well.
      ms_wrap     = (ms_q == MS_MAX);
      sec_wrap    = ms_wrap  && (sec_q == SEC_MAX);
      min_wrap    = sec_wrap && (min_q == MIN_MAX);
      hr_wrap     = min_wrap && (hr_q  == HR_MAX);
      if (load_ok) begin
         hr_d  = bus.load_hr;
         min_d = bus.load_min;
         sec_d = bus.load_sec;
         ms_d  = bus.load_ms;
      end else if (bus.load) begin
         set_err_d = 1'b1;
      end else if (advance) begin
         ms_d = ms_wrap ? '0 : ms_q + MS_W'(1);
         if (ms_wrap)  sec_d = sec_wrap ? '0 : sec_q + SEC_W'(1);
         if (sec_wrap) min_d = min_wrap ? '0 : min_q + MIN_W'(1);
         if (min_wrap) hr_d  = hr_wrap  ? '0 : hr_q  + HR_W'(1);
         sec_pulse_d = ms_wrap;
         day_wrap_d  = hr_wrap;
      end
`ifdef ALARM_EN
      alarm_hr_d  = alarm_hr_q;
      alarm_min_d = alarm_min_q;
      alarm_ok    = ({1'b0, bus.alarm_hr} < HR_LIM) && ({1'b0, bus.alarm_min} < MIN_LIM);
      if (bus.alarm_wr) begin
         if (alarm_ok) begin
            alarm_hr_d  = bus.alarm_hr;
            alarm_min_d = bus.alarm_min;
         end else begin
            set_err_d = 1'b1;
         end
      end
      alarm_hit_d = bus.alarm_arm && (load_ok || advance) &&
                    (hr_d == alarm_hr_q) && (min_d == alarm_min_q) &&
                    (sec_d == '0) && (ms_d == '0);
`endif
   end

   always_ff @(posedge kh_clk) begin
      if (reset) begin
         ms_q        <= '0;
         sec_q       <= '0;
         min_q       <= '0;
         hr_q        <= '0;
         sec_pulse_q <= 1'b0;
         day_wrap_q  <= 1'b0;
         set_err_q   <= 1'b0;
`ifdef ALARM_EN
         alarm_hr_q  <= '0;
         alarm_min_q <= '0;
         alarm_hit_q <= 1'b0;
`endif
      end else begin
         ms_q        <= ms_d;
         sec_q       <= sec_d;
         min_q       <= min_d;
         hr_q        <= hr_d;
         sec_pulse_q <= sec_pulse_d;
         day_wrap_q  <= day_wrap_d;
         set_err_q   <= set_err_d;
`ifdef ALARM_EN
         alarm_hr_q  <= alarm_hr_d;
         alarm_min_q <= alarm_min_d;
         alarm_hit_q <= alarm_hit_d;
`endif
      end
   end

   logic [HR_W-1:0] hr_disp;
   logic            pm_c;

   // 12-hour folding only makes sense for a 24-hour day; otherwise hours pass through.
   generate
      if (HR_MOD == 24) begin : g_12h
         always_comb begin
            hr_disp = hr_q;
            pm_c    = 1'b0;
            if (bus.mode_12h) begin
               if (hr_q == '0) begin
                  hr_disp = HR_W'(12);
               end else if (hr_q > HR_W'(12)) begin
                  hr_disp = hr_q - HR_W'(12);
                  pm_c    = 1'b1;
               end else if (hr_q == HR_W'(12)) begin
                  pm_c    = 1'b1;
               end
            end
         end
      end else begin : g_native
         assign hr_disp = hr_q;
         assign pm_c    = 1'b0;
      end
   endgenerate

   assign bus.disp_time = {hr_disp, min_q, sec_q, ms_q};
   assign bus.pm        = pm_c;
   assign bus.sec_pulse = sec_pulse_q;
   assign bus.day_wrap  = day_wrap_q;
   assign bus.set_err   = set_err_q;
`ifdef ALARM_EN
   assign bus.alarm_hit = alarm_hit_q;
`endif
endmodule

// File: tb/tb_clock_tod_param.sv
// Directed vector bench for clock_tod_param; alarm sequences included when ALARM_EN is defined.
module tb_clock_tod_param;
   logic kh_clk = 1'b0;
   logic reset  = 1'b1;
   always #5 kh_clk = ~kh_clk;

   clock_tod_param_if #(.MS_W(10), .SEC_W(6), .MIN_W(6), .HR_W(5)) bus ();
   clock_tod_param dut (.kh_clk(kh_clk), .reset(reset), .bus(bus));

   typedef struct {
      logic rst, ld, run, tk, m12;
      int   lh, lm, ls, lms, n;
      int   eh, em, es, ems;
      logic epm, esp, edw, eerr;
   } vec_t;

   vec_t vecs[$];
   int total = 0;
   int bad   = 0;

   function automatic vec_t mk(logic rst, logic ld, logic run, logic tk, logic m12,
                               int lh, int lm, int ls, int lms, int n,
                               int eh, int em, int es, int ems,
                               logic epm, logic esp, logic edw, logic eerr);
      vec_t v;
      v.rst = rst; v.ld = ld; v.run = run; v.tk = tk; v.m12 = m12;
      v.lh = lh; v.lm = lm; v.ls = ls; v.lms = lms; v.n = n;
      v.eh = eh; v.em = em; v.es = es; v.ems = ems;
      v.epm = epm; v.esp = esp; v.edw = edw; v.eerr = eerr;
      return v;
   endfunction

   function automatic logic [26:0] tod(int h, int m, int s, int ms);
      return {5'(h), 6'(m), 6'(s), 10'(ms)};
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge kh_clk);
      #1;
   endtask

   task automatic drive(logic ld, logic run, logic tk, logic m12, int lh, int lm, int ls, int lms);
      bus.load = ld; bus.run = run; bus.tick_en = tk; bus.mode_12h = m12;
      bus.load_hr = 5'(lh); bus.load_min = 6'(lm); bus.load_sec = 6'(ls); bus.load_ms = 10'(lms);
   endtask

`ifdef ALARM_EN
   task automatic alarm_seq(string tag, logic arm, logic exp_hit);
      bus.alarm_arm = arm;
      drive(1, 1, 1, 0, 7, 29, 59, 999);
      step();
      chk({tag, "_loadhit"}, 32'(bus.alarm_hit), 32'(1'b0));
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      step();
      chk({tag, "_time"}, 32'(bus.disp_time), 32'(tod(7, 30, 0, 0)));
      chk({tag, "_hit"}, 32'(bus.alarm_hit), 32'(exp_hit));
      step();
      chk({tag, "_hitgone"}, 32'(bus.alarm_hit), 32'(1'b0));
      $display("alarm %s arm=%0b hit_expected=%0b", tag, arm, exp_hit);
   endtask
`endif

   initial begin
      int pulses;
      int pulse_at;
      vec_t v;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef ALARM_EN
      bus.alarm_wr = 0; bus.alarm_hr = '0; bus.alarm_min = '0; bus.alarm_arm = 0;
`endif
      //          rst ld run tk m12  lh  lm  ls  lms   n   eh  em  es  ems  pm sp dw err
      vecs.push_back(mk(1, 0, 0, 0, 0,  0,  0,  0,   0,  1,   0,  0,  0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 23, 59, 59, 998,  1,  23, 59, 59, 998, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  1,  23, 59, 59, 999, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  1,   0,  0,  0,   0, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  1,   0,  0,  0,   1, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0,  5, 60,  0,   0,  1,   0,  0,  0,   1, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1, 0, 10, 20, 30, 400,  1,  10, 20, 30, 400, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0,  0,  0,  0,   0,500,  10, 20, 30, 400, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 0, 0,  0,  0,  0,   0,500,  10, 20, 30, 400, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  7,  10, 20, 30, 407, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0,  0,  0,  0,   0,  1,   0,  0,  0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1,  0,  0,  0,   0,  1,  12,  0,  0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 11,  0,  0,   0,  1,  11,  0,  0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 12,  0,  0,   0,  1,  12,  0,  0,   0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 1, 13,  0,  0,   0,  1,   1,  0,  0,   0, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0,  0,  0,  0,   0,  1,  13,  0,  0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0,  5,  6,  7,  89,  1,   5,  6,  7,  89, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  1,   5,  6,  7,  90, 0, 0, 0, 0));
      vecs.push_back(mk(1, 1, 1, 1, 0, 10, 20, 30, 400,  1,   0,  0,  0,   0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0, 24,  0,  0,   0,  1,   0,  0,  0,   0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1, 0,  0,  0,  0,1000,  1,   0,  0,  0,   0, 0, 0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 1, 0,  0,  0, 59, 999,  1,   0,  0, 59, 999, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  1,   0,  1,  0,   0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 0,  0, 59, 59, 999,  1,   0, 59, 59, 999, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 0,  0,  0,  0,   0,  1,   1,  0,  0,   0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, 1, 1, 1, 22, 59, 59, 999,  1,  10, 59, 59, 999, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 1, 1, 1,  0,  0,  0,   0,  1,  11,  0,  0,   0, 1, 1, 0, 0));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         reset = v.rst;
         drive(v.ld, v.run, v.tk, v.m12, v.lh, v.lm, v.ls, v.lms);
         repeat (v.n) step();
         chk($sformatf("v%0d_disp", i), 32'(bus.disp_time), 32'(tod(v.eh, v.em, v.es, v.ems)));
         chk($sformatf("v%0d_pm", i),   32'(bus.pm),        32'(v.epm));
         chk($sformatf("v%0d_sp", i),   32'(bus.sec_pulse), 32'(v.esp));
         chk($sformatf("v%0d_dw", i),   32'(bus.day_wrap),  32'(v.edw));
         chk($sformatf("v%0d_err", i),  32'(bus.set_err),   32'(v.eerr));
         $display("vec %0d: disp=%0h pm=%0b sp=%0b dw=%0b err=%0b bad_so_far=%0d",
                  i, bus.disp_time, bus.pm, bus.sec_pulse, bus.day_wrap, bus.set_err, bad);
      end

      // Display follows mode_12h without a clock edge; internal 23 h shown natively.
      bus.mode_12h = 1'b0;
      bus.run = 1'b0;
      #1;
      chk("mode_comb_disp", 32'(bus.disp_time), 32'(tod(23, 0, 0, 0)));
      chk("mode_comb_pm", 32'(bus.pm), 32'(1'b0));
      $display("mode toggle: disp=%0h pm=%0b", bus.disp_time, bus.pm);

      // Free-run from reset for 1000 ticks: exactly one sec_pulse, on the last one.
      reset = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      reset = 1'b0;
      drive(0, 1, 1, 0, 0, 0, 0, 0);
      pulses = 0;
      pulse_at = -1;
      for (int c = 1; c <= 1000; c++) begin
         step();
         if (bus.sec_pulse) begin
            pulses++;
            pulse_at = c;
         end
      end
      chk("run1000_disp", 32'(bus.disp_time), 32'(tod(0, 0, 1, 0)));
      chk("run1000_pulses", 32'(pulses), 32'd1);
      chk("run1000_pulse_at", 32'(pulse_at), 32'd1000);
      $display("run1000: disp=%0h pulses=%0d at=%0d", bus.disp_time, pulses, pulse_at);

`ifdef ALARM_EN
      bus.alarm_wr = 1; bus.alarm_hr = 5'd7; bus.alarm_min = 6'd30;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("alarm_wr_err", 32'(bus.set_err), 32'(1'b0));
      bus.alarm_wr = 0;
      alarm_seq("armed", 1'b1, 1'b1);
      alarm_seq("disarmed", 1'b0, 1'b0);
      bus.alarm_wr = 1; bus.alarm_hr = 5'd7; bus.alarm_min = 6'd60;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      step();
      chk("alarm_bad_err", 32'(bus.set_err), 32'(1'b1));
      bus.alarm_wr = 0;
      alarm_seq("kept", 1'b1, 1'b1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
